// File: rtl/mem_access_if.sv
// Single-master data bus between the memory-access stage and memory.
// The stage holds the request until bus_ack_i; read data is valid with the ack.
interface mem_access_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: loads/stores over a request/ack bus, then a one-cycle strobe to write-back.
// Latency 1 cycle (non-memory) or 2 + bus wait cycles; accepts only in IDLE (one instruction per 2 cycles max).
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [31:0]  ir_i,
    input  logic [31:0]  pc_i,
    input  logic [31:0]  alu_i,
    input  logic [31:0]  rs2_i,
    mem_access_if.master bus,
    output logic [31:0]  ir_o,
    output logic [31:0]  pc_o,
    output logic [31:0]  wd_o,
    output logic [31:0]  mem_o,
    output logic         wd_q_readin_o,
    output logic         fault_o
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_q;
    logic        ready_q, req_q, we_q, strb_q, fault_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;
    logic [7:0]  cnt_q;
    logic [31:0] ir_q, pc_q, alu_q;
    logic [31:0] wb_ir_q, wb_pc_q, wb_wd_q, wb_mem_q;

    logic        is_ld_d, is_st_d, mem_op_d, sz_byte_d, sz_half_d, misal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext_d;

    // Access width: loads use funct3[1:0] only; stores with funct3[2] set are words.
    always_comb begin
        is_ld_d   = (ir_i[6:0] == OP_LOAD);
        is_st_d   = (ir_i[6:0] == OP_STORE);
        mem_op_d  = is_ld_d || is_st_d;
        sz_byte_d = (ir_i[13:12] == 2'b00) && (is_ld_d || !ir_i[14]);
        sz_half_d = (ir_i[13:12] == 2'b01) && (is_ld_d || !ir_i[14]);
        misal_d   = mem_op_d && (sz_half_d ? alu_i[0]
                                           : (!sz_byte_d && (alu_i[1:0] != 2'b00)));
        if (sz_byte_d) begin
            be_d    = 4'b0001 << alu_i[1:0];
            wdata_d = {4{rs2_i[7:0]}};
        end else if (sz_half_d) begin
            be_d    = alu_i[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{rs2_i[15:0]}};
        end else begin
            be_d    = 4'b1111;
            wdata_d = rs2_i;
        end
    end

    always_comb begin
        ld_byte = bus.bus_rdata_i[{alu_q[1:0], 3'b000} +: 8];
        ld_half = alu_q[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];
        case (ir_q[14:12])
            3'b000:  ld_ext_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext_d = {24'h0, ld_byte};
            3'b101:  ld_ext_d = {16'h0, ld_half};
            default: ld_ext_d = bus.bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cnt_q    <= 8'h0;
            strb_q   <= 1'b0;
            fault_q  <= 1'b0;
            ir_q     <= 32'h0;
            pc_q     <= 32'h0;
            alu_q    <= 32'h0;
            wb_ir_q  <= 32'h0;
            wb_pc_q  <= 32'h0;
            wb_wd_q  <= 32'h0;
            wb_mem_q <= 32'h0;
        end else begin
            strb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        ir_q    <= ir_i;
                        pc_q    <= pc_i;
                        alu_q   <= alu_i;
                        addr_q  <= {alu_i[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        cnt_q   <= 8'h0;
                        ready_q <= 1'b0;
                        if (mem_op_d && !misal_d) begin
                            state_q <= BUS;
                            req_q   <= 1'b1;
                            we_q    <= is_st_d;
                            be_q    <= is_st_d ? be_d : 4'h0;
                        end else begin
                            // Misaligned L/S skip the bus but still retire so the PC advances.
                            state_q  <= DONE;
                            strb_q   <= 1'b1;
                            wb_ir_q  <= ir_i;
                            wb_pc_q  <= pc_i;
                            wb_wd_q  <= alu_i;
                            wb_mem_q <= 32'h0;
                            if (misal_d) fault_q <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (bus.bus_ack_i || (cnt_q == TMO_LAST)) begin
                        state_q  <= DONE;
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        be_q     <= 4'h0;
                        strb_q   <= 1'b1;
                        wb_ir_q  <= ir_q;
                        wb_pc_q  <= pc_q;
                        wb_wd_q  <= alu_q;
                        wb_mem_q <= (bus.bus_ack_i && !we_q) ? ld_ext_d : 32'h0;
                        if (!bus.bus_ack_i) fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o         = ready_q;
    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_be_o    = be_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign ir_o            = wb_ir_q;
    assign pc_o            = wb_pc_q;
    assign wd_o            = wb_wd_q;
    assign mem_o           = wb_mem_q;
    assign wd_q_readin_o   = strb_q;
    assign fault_o         = fault_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level model plus per-cycle compare.
module tb_mem_access;
    localparam int TMO = 16;

    typedef struct packed {
        logic [31:0] ir, pc, alu, rs2, rdata;
        int          delay;          // ack on bus cycle delay+1; -1 = never
    } item_t;

    typedef struct packed {
        logic        fault, we;
        logic [3:0]  be;
        logic [31:0] addr, wdata, mem;
        int          nreq, sk;       // request cycles, strobe cycle (counted from accept)
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, valid_i, ready_o, wd_q_readin_o, fault_o;
    logic [31:0] ir_i, pc_i, alu_i, rs2_i, ir_o, pc_o, wd_o, mem_o;

    mem_access_if bus ();

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .ir_i(ir_i), .pc_i(pc_i), .alu_i(alu_i), .rs2_i(rs2_i), .bus(bus),
        .ir_o(ir_o), .pc_o(pc_o), .wd_o(wd_o), .mem_o(mem_o),
        .wd_q_readin_o(wd_q_readin_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0, acc = 0;
    logic chk_on = 1'b0, active = 1'b0, exp_fault = 1'b0;
    item_t cur;
    exp_t  ex;
    logic [31:0] last_ir = 0, last_pc = 0, last_wd = 0, last_mem = 0;
    int obs_reqs, obs_sk;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        n_vec++;
        if (act !== exv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exv, cyc);
        end
    endtask

    function automatic item_t mk(input logic [31:0] ir, pc, alu, rs2, rdata, input int delay);
        item_t t;
        t.ir = ir; t.pc = pc; t.alu = alu; t.rs2 = rs2; t.rdata = rdata; t.delay = delay;
        return t;
    endfunction

    // Outcome of one instruction from the architectural rules: size, alignment, lanes, extension.
    function automatic exp_t model(input item_t t);
        exp_t e;
        int sz, lane;
        logic ld, st, timed;
        logic [31:0] v, msk;
        e = '0;
        ld = (t.ir[6:0] == 7'b0000011);
        st = (t.ir[6:0] == 7'b0100011);
        lane = int'(t.alu[1:0]);
        case (t.ir[13:12])
            2'b00:   sz = 1;
            2'b01:   sz = 2;
            default: sz = 4;
        endcase
        if (st && t.ir[14]) sz = 4;
        if ((ld || st) && (lane % sz == 0)) begin
            timed  = (t.delay < 0) || (t.delay >= TMO);
            e.nreq = timed ? TMO : t.delay + 1;
            e.sk   = e.nreq + 1;
            e.we   = st;
            e.be   = 4'(((1 << sz) - 1) << lane);
            e.addr = t.alu & 32'hFFFF_FFFC;
            for (int b = 0; b < 4; b++) e.wdata[8*b +: 8] = t.rs2[8*(b % sz) +: 8];
            e.fault = timed;
            if (ld && !timed) begin
                v = t.rdata >> (8 * lane);
                if (sz < 4) begin
                    msk = (32'h1 << (8 * sz)) - 32'h1;
                    v = v & msk;
                    if (!t.ir[14] && v[8*sz-1]) v = v | ~msk;
                end
                e.mem = v;
            end
        end else begin
            e.nreq  = 0;
            e.sk    = 1;
            e.fault = (ld || st);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            int k;
            logic e_req, e_stb, e_rdy, e_flt;
            logic [31:0] e_ir, e_pc, e_wd, e_mem;
            e_req = 1'b0; e_stb = 1'b0; e_rdy = 1'b1; e_flt = exp_fault;
            e_ir = last_ir; e_pc = last_pc; e_wd = last_wd; e_mem = last_mem;
            if (active) begin
                k = cyc - acc + 1;
                e_req = (k <= ex.nreq);
                e_stb = (k == ex.sk);
                e_rdy = 1'b0;
                if (k >= ex.sk) begin
                    e_ir = cur.ir; e_pc = cur.pc; e_wd = cur.alu; e_mem = ex.mem;
                    e_flt = exp_fault | ex.fault;
                end
            end
            chk("req", 32'(bus.bus_req_o), 32'(e_req));
            chk("we", 32'(bus.bus_we_o), 32'(e_req & ex.we));
            chk("be", 32'(bus.bus_be_o), (e_req && ex.we) ? 32'(ex.be) : 32'h0);
            if (e_req) begin
                chk("addr", bus.bus_addr_o, ex.addr);
                if (ex.we) chk("wdata", bus.bus_wdata_o, ex.wdata);
            end
            chk("strobe", 32'(wd_q_readin_o), 32'(e_stb));
            chk("ready", 32'(ready_o), 32'(e_rdy));
            chk("fault", 32'(fault_o), 32'(e_flt));
            chk("ir_o", ir_o, e_ir);
            chk("pc_o", pc_o, e_pc);
            chk("wd_o", wd_o, e_wd);
            chk("mem_o", mem_o, e_mem);
        end
    end

    // Caller sits 1 time unit after a rising edge with the DUT idle.
    task automatic start_item(input item_t t);
        valid_i = 1'b1; ir_i = t.ir; pc_i = t.pc; alu_i = t.alu; rs2_i = t.rs2;
        bus.bus_rdata_i = t.rdata;
        @(posedge clk); #1;
        valid_i = 1'b0; ir_i = ~t.ir; pc_i = ~t.pc; alu_i = ~t.alu; rs2_i = ~t.rs2;
        cur = t; ex = model(t); acc = cyc; active = 1'b1;
    endtask

    task automatic run_item(input item_t t);
        start_item(t);
        obs_reqs = 0; obs_sk = 0;
        for (int j = 1; j <= ex.sk; j++) begin
            bus.bus_ack_i = (t.delay == j - 1);
            if (bus.bus_req_o) obs_reqs++;
            if (wd_q_readin_o && obs_sk == 0) obs_sk = j;
            if (j == 1) begin
                obs_addr = bus.bus_addr_o; obs_be = bus.bus_be_o;
                obs_wdata = bus.bus_wdata_o; obs_we = bus.bus_we_o;
            end
            @(posedge clk); #1;
        end
        bus.bus_ack_i = 1'b0;
        last_ir = t.ir; last_pc = t.pc; last_wd = t.alu; last_mem = ex.mem;
        exp_fault = exp_fault | ex.fault;
        active = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; active = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        last_ir = 0; last_pc = 0; last_wd = 0; last_mem = 0; exp_fault = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid_i = 1'b0; ir_i = 0; pc_i = 0; alu_i = 0; rs2_i = 0;
        bus.bus_ack_i = 1'b0; bus.bus_rdata_i = 32'h0;
        repeat (3) @(posedge clk); #1;
        chk("rst_ready", 32'(ready_o), 32'h1);
        chk("rst_req", 32'(bus.bus_req_o), 32'h0);
        chk("rst_strobe", 32'(wd_q_readin_o), 32'h0);
        chk("rst_fault", 32'(fault_o), 32'h0);
        chk("rst_mem", mem_o, 32'h0);
        reset = 1'b0; chk_on = 1'b1;

        run_item(mk(32'h002081B3, 32'h40, 32'h15, 32'h0, 32'hFFFF_FFFF, 0)); // add, stray ack
        chk("add_wd", wd_o, 32'h15); chk("add_pc", pc_o, 32'h40);
        chk("add_sk", 32'(obs_sk), 32'd1); chk("add_reqs", 32'(obs_reqs), 32'd0);

        run_item(mk(32'h00000083, 32'h44, 32'h1003, 32'h0, 32'h80FF_FF7F, 0)); // LB
        chk("lb_addr", obs_addr, 32'h1000); chk("lb_be", 32'(obs_be), 32'h0);
        chk("lb_mem", mem_o, 32'hFFFF_FF80); chk("lb_sk", 32'(obs_sk), 32'd2);

        run_item(mk(32'h00001023, 32'h48, 32'h2002, 32'h1234_ABCD, 32'h0, 3)); // SH
        chk("sh_be", 32'(obs_be), 32'hC); chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(obs_we), 32'h1); chk("sh_reqs", 32'(obs_reqs), 32'd4);
        chk("sh_sk", 32'(obs_sk), 32'd5); chk("sh_mem", mem_o, 32'h0);

        run_item(mk(32'h00001003, 32'h4C, 32'h5000, 32'h0, 32'h1234_8001, 1)); // LH
        chk("lh_mem", mem_o, 32'hFFFF_8001);
        run_item(mk(32'h00005003, 32'h50, 32'h5002, 32'h0, 32'h8001_7FFF, 0)); // LHU
        chk("lhu_mem", mem_o, 32'h0000_8001);
        run_item(mk(32'h00004003, 32'h54, 32'h5001, 32'h0, 32'h0000_F000, 0)); // LBU
        chk("lbu_mem", mem_o, 32'h0000_00F0);
        run_item(mk(32'h00000023, 32'h58, 32'h6002, 32'h0000_00AA, 32'h0, 0)); // SB
        chk("sb_be", 32'(obs_be), 32'h4); chk("sb_wdata", obs_wdata, 32'hAAAA_AAAA);
        run_item(mk(32'h00002023, 32'h5C, 32'h6004, 32'hCAFE_F00D, 32'h0, 2)); // SW
        run_item(mk(32'h00003003, 32'h60, 32'h6008, 32'h0, 32'hDEAD_BEEF, 0)); // load funct3=011
        chk("ld011_mem", mem_o, 32'hDEAD_BEEF);
        run_item(mk(32'h00108093, 32'h64, 32'h77, 32'h0, 32'h0, -1));          // addi
        chk("fault_clean", 32'(fault_o), 32'h0);

        run_item(mk(32'h00002003, 32'h68, 32'h3001, 32'h0, 32'h1111_1111, 0)); // LW misaligned
        chk("mis_reqs", 32'(obs_reqs), 32'd0); chk("mis_fault", 32'(fault_o), 32'h1);
        chk("mis_mem", mem_o, 32'h0); chk("mis_sk", 32'(obs_sk), 32'd1);
        run_item(mk(32'h00004023, 32'h6C, 32'h7002, 32'h5, 32'h0, 0));        // store funct3=100 misaligned
        chk("st100_reqs", 32'(obs_reqs), 32'd0);

        do_reset();
        run_item(mk(32'h00002083, 32'h70, 32'h4000, 32'h0, 32'h2222_2222, -1)); // LW timeout
        chk("tmo_reqs", 32'(obs_reqs), 32'd16); chk("tmo_fault", 32'(fault_o), 32'h1);
        chk("tmo_sk", 32'(obs_sk), 32'd17); chk("tmo_ready", 32'(ready_o), 32'h1);
        chk("tmo_mem", mem_o, 32'h0);

        do_reset();
        run_item(mk(32'h00002083, 32'h74, 32'h4004, 32'h0, 32'h3333_4444, 15)); // ack on cycle 16
        chk("ack16_reqs", 32'(obs_reqs), 32'd16); chk("ack16_fault", 32'(fault_o), 32'h0);
        chk("ack16_mem", mem_o, 32'h3333_4444);

        start_item(mk(32'h00002083, 32'h78, 32'h4008, 32'h0, 32'h0, -1));      // abort by reset
        bus.bus_ack_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_req_hi", 32'(bus.bus_req_o), 32'h1);
        do_reset();
        chk("abort_req", 32'(bus.bus_req_o), 32'h0); chk("abort_ready", 32'(ready_o), 32'h1);
        chk("abort_strobe", 32'(wd_q_readin_o), 32'h0);
        run_item(mk(32'h00002083, 32'h7C, 32'h400C, 32'h0, 32'h5555_6666, 1));
        chk("post_mem", mem_o, 32'h5555_6666); chk("post_pc", pc_o, 32'h7C);
        chk("post_fault", 32'(fault_o), 32'h0);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
